i2c_req_arbiter: RTL and testbench

I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

---
 rtl/i2c_req_arbiter_pkg.sv | 21 ++
 rtl/i2c_req_arbiter_rr_picker.sv | 32 +++
 rtl/i2c_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_req_arbiter_pkg.sv
// Shared I2C definitions: default address/data widths and the arbiter state encoding.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package i2c_req_arbiter_pkg;

  localparam int I2C_ADDR_LEN = 7;
  localparam int I2C_DATA_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  // Next requester index after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_picker.sv
// Round-robin search: first requester at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; vld is low when no requester is asserting req.
module rr_picker
  import i2c_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               vld
);

  logic [PTR_W-1:0] idx;

  // Walk ptr, ptr+1, ... and keep the first asserted request.
  always_comb begin
    winner = '0;
    vld    = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!vld && req[idx]) begin
        winner[idx] = 1'b1;
        vld         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master among NUM_REQ requesters with round-robin grants and a start timeout.
// Latency: grant 1 cycle after an idle-master request, m_start 1 cycle after grant, done 1 cycle after free.
// Backpressure: no grant while m_free is low; requesters hold req until their done pulse.
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_LEN      = I2C_ADDR_LEN,
  parameter int DATA_LEN      = I2C_DATA_LEN,
  parameter int START_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_LEN-1:0] req_addr,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_data1,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_data2,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic                        m_start,
  output logic [ADDR_LEN-1:0]         m_add_reg,
  output logic                        m_R_W,
  output logic [DATA_LEN-1:0]         m_data_1,
  output logic [DATA_LEN-1:0]         m_data_2,
  input  logic                        m_free
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_t state, state_nxt;

  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [PTR_W-1:0]    own_idx, own_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  pick;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [ADDR_LEN-1:0] sel_addr;
  logic                sel_rw;
  logic [DATA_LEN-1:0] sel_d1, sel_d2;
  logic                start_expired;

  logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
  logic                err_nxt, m_start_nxt, m_rw_nxt;
  logic [ADDR_LEN-1:0] m_add_nxt;
  logic [DATA_LEN-1:0] m_d1_nxt, m_d2_nxt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .vld    (pick_vld)
  );

  // The counter only advances once m_start is visible, so the start window spans START_TIMEOUT cycles of m_start.
  assign start_expired = m_start && (cnt == CNT_W'(START_TIMEOUT - 1));

  // Convert the one-hot winner into an index and select its transaction fields.
  always_comb begin
    pick_idx = '0;
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_d1   = '0;
    sel_d2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
        sel_addr = req_addr[i*ADDR_LEN +: ADDR_LEN];
        sel_rw   = req_rw[i];
        sel_d1   = req_data1[i*DATA_LEN +: DATA_LEN];
        sel_d2   = req_data2[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (m_free && pick_vld) state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        if (!m_free)            state_nxt = ST_BUSY;
        else if (start_expired) state_nxt = ST_DONE;
      end
      ST_BUSY:   if (m_free) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of every registered output and of the arbitration bookkeeping.
  always_comb begin
    gnt_nxt     = gnt;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    m_start_nxt = 1'b0;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    own_nxt     = own_idx;
    m_add_nxt   = m_add_reg;
    m_rw_nxt    = m_R_W;
    m_d1_nxt    = m_data_1;
    m_d2_nxt    = m_data_2;
    unique case (state)
      ST_IDLE: begin
        if (m_free && pick_vld) begin
          gnt_nxt   = pick;
          own_nxt   = pick_idx;
          cnt_nxt   = '0;
          m_add_nxt = sel_addr;
          m_rw_nxt  = sel_rw;
          m_d1_nxt  = sel_d1;
          m_d2_nxt  = sel_d2;
        end
      end
      ST_LAUNCH: begin
        // A low m_free means the master took the start: drop m_start and wait in BUSY.
        if (m_free) begin
          if (start_expired) begin
            err_nxt  = 1'b1;
            done_nxt = gnt;
            gnt_nxt  = '0;
          end else begin
            m_start_nxt = 1'b1;
            if (m_start) cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_BUSY: begin
        if (m_free) begin
          done_nxt = gnt;
          gnt_nxt  = '0;
        end
      end
      ST_DONE: begin
        // The finished owner drops to lowest priority for the next arbitration.
        ptr_nxt = PTR_W'(rr_next(int'(own_idx), NUM_REQ));
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers; reset clears everything, aborting any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      m_start   <= 1'b0;
      m_add_reg <= '0;
      m_R_W     <= 1'b0;
      m_data_1  <= '0;
      m_data_2  <= '0;
      cnt       <= '0;
      ptr       <= '0;
      own_idx   <= '0;
    end else begin
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      m_start   <= m_start_nxt;
      m_add_reg <= m_add_nxt;
      m_R_W     <= m_rw_nxt;
      m_data_1  <= m_d1_nxt;
      m_data_2  <= m_d2_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      own_idx   <= own_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: scenario tasks plus randomized traffic against a rotation model.
// Latency: n/a.
// Backpressure: a behavioural master model drives m_free.
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int AL = 7;
  localparam int DL = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AL-1:0] req_addr;
  logic [N-1:0]  req_rw;
  logic [N*DL-1:0] req_data1, req_data2;
  logic [N-1:0]  gnt, done;
  logic          err, m_start;
  logic [AL-1:0] m_add_reg;
  logic          m_R_W;
  logic [DL-1:0] m_data_1, m_data_2;
  logic          m_free;

  int checks   = 0;
  int failures = 0;
  int mdl_ptr  = 0;

  logic [AL-1:0] t_addr [N];
  logic          t_rw   [N];
  logic [DL-1:0] t_d1   [N];
  logic [DL-1:0] t_d2   [N];

  logic mst_auto = 1'b0;
  int   drop_dly = 2;
  int   busy_len = 20;

  i2c_req_arbiter #(
    .NUM_REQ(N), .ADDR_LEN(AL), .DATA_LEN(DL), .START_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_data1(req_data1), .req_data2(req_data2), .gnt(gnt), .done(done), .err(err),
    .m_start(m_start), .m_add_reg(m_add_reg), .m_R_W(m_R_W), .m_data_1(m_data_1),
    .m_data_2(m_data_2), .m_free(m_free)
  );

  always #5 clk = ~clk;

  // Master model: drop free drop_dly cycles after seeing start, stay busy busy_len cycles.
  initial begin
    m_free = 1'b1;
    forever begin
      @(negedge clk);
      if (mst_auto && m_start && m_free) begin
        repeat (drop_dly) @(negedge clk);
        m_free = 1'b0;
        repeat (busy_len) @(negedge clk);
        m_free = 1'b1;
      end
    end
  end

  // Reference rotation: first requester at or after p, wrapping.
  function automatic int mdl_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic pack_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AL +: AL]  = t_addr[i];
      req_rw[i]             = t_rw[i];
      req_data1[i*DL +: DL] = t_d1[i];
      req_data2[i*DL +: DL] = t_d2[i];
    end
  endtask

  task automatic random_fields();
    for (int i = 0; i < N; i++) begin
      t_addr[i] = AL'($urandom);
      t_rw[i]   = 1'($urandom);
      t_d1[i]   = DL'($urandom);
      t_d2[i]   = DL'($urandom);
    end
    pack_fields();
  endtask

  // Bounded wait for a nonzero grant; g stays 0 if the budget expires.
  task automatic wait_gnt(input int budget, output logic [N-1:0] g, output int waited);
    g = '0;
    waited = 0;
    while (waited < budget && g == '0) begin
      @(negedge clk);
      waited++;
      g = gnt;
    end
  endtask

  // Observe a granted transaction until its done pulse (bounded), plus the cycle after.
  task automatic watch_txn(input int budget, input int mut_cycle,
                           output int starts, output logic first_start,
                           output logic [N-1:0] done_v, output logic err_v,
                           output logic gnt_ok, output logic data_stable, output logic stray_err,
                           output logic [N-1:0] done_after, output logic err_after);
    logic [N-1:0]  g0;
    logic [AL-1:0] a0;
    logic          r0;
    logic [DL-1:0] d10, d20;
    g0 = gnt; a0 = m_add_reg; r0 = m_R_W; d10 = m_data_1; d20 = m_data_2;
    starts = 0; first_start = 1'b0; done_v = '0; err_v = 1'b0;
    gnt_ok = 1'b1; data_stable = 1'b1; stray_err = 1'b0;
    for (int c = 1; c <= budget && done_v == '0; c++) begin
      @(negedge clk);
      if (c == 1) first_start = m_start;
      if (m_start) starts++;
      if (err && done == '0) stray_err = 1'b1;
      if (m_add_reg !== a0 || m_R_W !== r0 || m_data_1 !== d10 || m_data_2 !== d20) data_stable = 1'b0;
      if (done != '0) begin
        done_v = done;
        err_v  = err;
        if (gnt != '0) gnt_ok = 1'b0;
      end else if (gnt !== g0) begin
        gnt_ok = 1'b0;
      end
      if (c == mut_cycle) begin
        req = '0;
        req_data1[DL-1:0] = 8'h22;
      end
    end
    @(negedge clk);
    done_after = done;
    err_after  = err;
  endtask

  task automatic test_reset();
    req = '0; mst_auto = 1'b0; rst = 1'b1;
    random_fields();
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0)       begin failures++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0)      begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)     begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (m_start !== 1'b0) begin failures++; $display("FAIL reset_m_start: got %b want 0", m_start); end
    checks++; if (m_add_reg !== '0 || m_R_W !== 1'b0 || m_data_1 !== '0 || m_data_2 !== '0) begin
      failures++; $display("FAIL reset_m_fields: got %h/%b/%h/%h want 0", m_add_reg, m_R_W, m_data_1, m_data_2);
    end
    rst = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_single();
    logic [N-1:0] g, dv, da; logic fs, ev, gok, ds, se, ea; int w, st;
    t_addr[0] = 7'h50; t_rw[0] = 1'b0; t_d1[0] = 8'hA5; t_d2[0] = 8'h3C;
    pack_fields();
    drop_dly = 2; busy_len = 20; mst_auto = 1'b1;
    req = 4'b0001;
    wait_gnt(20, g, w);
    checks++; if (g !== 4'b0001)     begin failures++; $display("FAIL single_gnt: got %b want 0001", g); end
    checks++; if (m_add_reg !== 7'h50) begin failures++; $display("FAIL single_addr: got %h want 50", m_add_reg); end
    checks++; if (m_data_1 !== 8'hA5 || m_data_2 !== 8'h3C || m_R_W !== 1'b0) begin
      failures++; $display("FAIL single_data: got %h/%h rw %b want a5/3c rw 0", m_data_1, m_data_2, m_R_W);
    end
    checks++; if (m_start !== 1'b0)  begin failures++; $display("FAIL single_start_at_gnt: got %b want 0", m_start); end
    watch_txn(200, 0, st, fs, dv, ev, gok, ds, se, da, ea);
    checks++; if (fs !== 1'b1)  begin failures++; $display("FAIL single_start_latency: got %b want 1", fs); end
    checks++; if (st != 3)      begin failures++; $display("FAIL single_start_len: got %0d want 3", st); end
    checks++; if (dv !== 4'b0001 || ev !== 1'b0) begin failures++; $display("FAIL single_done: got %b err %b want 0001 err 0", dv, ev); end
    checks++; if (da !== '0 || !gok || se) begin failures++; $display("FAIL single_pulse: after %b gnt_ok %b stray %b want 0/1/0", da, gok, se); end
    req = '0;
    mdl_ptr = 1;
  endtask

  task automatic test_rotation();
    logic [N-1:0] g, ex, dv, da; logic fs, ev, gok, ds, se, ea; int w, st, k;
    random_fields();
    drop_dly = 1; busy_len = 3; mst_auto = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    req = 4'b1111; rst = 1'b0; mdl_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      k  = mdl_pick(req, mdl_ptr);
      ex = onehot(k);
      wait_gnt(10, g, w);
      checks++; if (g !== ex) begin failures++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, g, ex); end
      checks++; if (w != 1)   begin failures++; $display("FAIL rot_gap[%0d]: got %0d want 1", i, w); end
      checks++; if (m_add_reg !== t_addr[k] || m_data_1 !== t_d1[k]) begin
        failures++; $display("FAIL rot_fields[%0d]: got %h/%h want %h/%h", i, m_add_reg, m_data_1, t_addr[k], t_d1[k]);
      end
      watch_txn(100, 0, st, fs, dv, ev, gok, ds, se, da, ea);
      checks++; if (dv !== ex || ev !== 1'b0 || da !== '0) begin
        failures++; $display("FAIL rot_done[%0d]: got %b err %b after %b want %b err 0 after 0", i, dv, ev, da, ex);
      end
      mdl_ptr = (k + 1) % N;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] g, dv, da; logic fs, ev, gok, ds, se, ea; int w, st, k;
    mst_auto = 1'b0;
    req = 4'b0100;
    wait_gnt(10, g, w);
    checks++; if (g !== 4'b0100) begin failures++; $display("FAIL to_gnt: got %b want 0100", g); end
    watch_txn(200, 0, st, fs, dv, ev, gok, ds, se, da, ea);
    checks++; if (st != TO) begin failures++; $display("FAIL to_start_len: got %0d want %0d", st, TO); end
    checks++; if (dv !== 4'b0100 || ev !== 1'b1) begin failures++; $display("FAIL to_done: got %b err %b want 0100 err 1", dv, ev); end
    checks++; if (da !== '0 || ea !== 1'b0 || se) begin failures++; $display("FAIL to_err_pulse: after %b err %b stray %b want 0/0/0", da, ea, se); end
    mdl_ptr = 3;
    req = 4'b1111;
    k = mdl_pick(req, mdl_ptr);
    wait_gnt(10, g, w);
    mst_auto = 1'b1;
    checks++; if (g !== onehot(k)) begin failures++; $display("FAIL to_ptr_adv: got %b want %b", g, onehot(k)); end
    watch_txn(100, 0, st, fs, dv, ev, gok, ds, se, da, ea);
    checks++; if (dv !== onehot(k) || ev !== 1'b0) begin failures++; $display("FAIL to_next_done: got %b err %b want %b err 0", dv, ev, onehot(k)); end
    req = '0;
    mdl_ptr = (k + 1) % N;
  endtask

  task automatic test_busy_master();
    logic [N-1:0] g, dv, da; logic fs, ev, gok, ds, se, ea, any_gnt; int st;
    mst_auto = 1'b0;
    m_free = 1'b0;
    req = 4'b0010;
    any_gnt = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gnt != '0) any_gnt = 1'b1;
    end
    checks++; if (any_gnt !== 1'b0) begin failures++; $display("FAIL busy_no_gnt: got %b want 0", any_gnt); end
    m_free = 1'b1;
    @(negedge clk);
    g = gnt;
    mst_auto = 1'b1;
    checks++; if (g !== 4'b0010) begin failures++; $display("FAIL busy_gnt_after_free: got %b want 0010", g); end
    watch_txn(100, 0, st, fs, dv, ev, gok, ds, se, da, ea);
    checks++; if (dv !== 4'b0010 || ev !== 1'b0) begin failures++; $display("FAIL busy_done: got %b err %b want 0010 err 0", dv, ev); end
    req = '0;
    mdl_ptr = 2;
  endtask

  task automatic test_reset_mid_busy();
    logic [N-1:0] g, dv, da; logic fs, ev, gok, ds, se, ea, saw_done; int w, st;
    random_fields();
    drop_dly = 2; busy_len = 20; mst_auto = 1'b1;
    req = 4'b0100;
    wait_gnt(10, g, w);
    checks++; if (g !== 4'b0100) begin failures++; $display("FAIL rstb_gnt: got %b want 0100", g); end
    repeat (6) @(negedge clk);
    checks++; if (m_start !== 1'b0 || gnt !== 4'b0100) begin failures++; $display("FAIL rstb_busy: start %b gnt %b want 0/0100", m_start, gnt); end
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (gnt !== '0 || done !== '0 || err !== 1'b0 || m_start !== 1'b0) begin
      failures++; $display("FAIL rstb_ctrl_zero: gnt %b done %b err %b start %b want 0", gnt, done, err, m_start);
    end
    checks++; if (m_add_reg !== '0 || m_R_W !== 1'b0 || m_data_1 !== '0 || m_data_2 !== '0) begin
      failures++; $display("FAIL rstb_fields_zero: got %h/%b/%h/%h want 0", m_add_reg, m_R_W, m_data_1, m_data_2);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done != '0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rstb_no_done: got %b want 0", saw_done); end
    mdl_ptr = 0;
    req = 4'b1111;
    wait_gnt(10, g, w);
    checks++; if (g !== onehot(mdl_pick(4'b1111, mdl_ptr))) begin failures++; $display("FAIL rstb_restart_idx: got %b want 0001", g); end
    watch_txn(100, 0, st, fs, dv, ev, gok, ds, se, da, ea);
    req = '0;
    mdl_ptr = 1;
  endtask

  task automatic test_input_stability();
    logic [N-1:0] g, dv, da; logic fs, ev, gok, ds, se, ea; int w, st;
    t_d1[0] = 8'h11;
    pack_fields();
    drop_dly = 2; busy_len = 20; mst_auto = 1'b1;
    req = 4'b0001;
    wait_gnt(10, g, w);
    checks++; if (g !== 4'b0001 || m_data_1 !== 8'h11) begin failures++; $display("FAIL stab_gnt: got %b/%h want 0001/11", g, m_data_1); end
    watch_txn(200, 8, st, fs, dv, ev, gok, ds, se, da, ea);
    checks++; if (ds !== 1'b1 || m_data_1 !== 8'h11) begin failures++; $display("FAIL stab_data: stable %b data %h want 1/11", ds, m_data_1); end
    checks++; if (dv !== 4'b0001 || ev !== 1'b0) begin failures++; $display("FAIL stab_done: got %b err %b want 0001 err 0", dv, ev); end
    req = '0;
    mdl_ptr = 1;
  endtask

  task automatic test_random_traffic();
    logic [N-1:0] g, ex, r, dv, da; logic fs, ev, gok, ds, se, ea; int w, st, k;
    for (int i = 0; i < 12; i++) begin
      random_fields();
      r = N'($urandom_range(1, 15));
      drop_dly = int'($urandom_range(1, 4));
      busy_len = int'($urandom_range(1, 8));
      mst_auto = 1'b1;
      k  = mdl_pick(r, mdl_ptr);
      ex = onehot(k);
      req = r;
      wait_gnt(10, g, w);
      checks++; if (g !== ex) begin failures++; $display("FAIL rnd_gnt[%0d]: req %b got %b want %b", i, r, g, ex); end
      checks++; if (m_add_reg !== t_addr[k] || m_R_W !== t_rw[k] || m_data_1 !== t_d1[k] || m_data_2 !== t_d2[k]) begin
        failures++; $display("FAIL rnd_fields[%0d]: got %h/%b/%h/%h want %h/%b/%h/%h", i, m_add_reg, m_R_W, m_data_1, m_data_2, t_addr[k], t_rw[k], t_d1[k], t_d2[k]);
      end
      watch_txn(100, 0, st, fs, dv, ev, gok, ds, se, da, ea);
      checks++; if (st != drop_dly + 1) begin failures++; $display("FAIL rnd_start_len[%0d]: got %0d want %0d", i, st, drop_dly + 1); end
      checks++; if (dv !== ex || ev !== 1'b0 || !gok || !ds) begin
        failures++; $display("FAIL rnd_done[%0d]: got %b err %b gnt_ok %b stable %b want %b/0/1/1", i, dv, ev, gok, ds, ex);
      end
      req = '0;
      mdl_ptr = (k + 1) % N;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_data1 = '0; req_data2 = '0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_busy_master();
    test_reset_mid_busy();
    test_input_stability();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
